// File: rtl/core_pkg.sv
// Shared opcode map, flag layout and class decode for the 8-bit core.
// Imported by every pipeline stage.
package core_pkg;

    localparam int OP_W = 5;

    localparam logic [OP_W-1:0] OP_MOVE    = 5'b00000;
    localparam logic [OP_W-1:0] OP_MUL     = 5'b00011;
    localparam logic [OP_W-1:0] OP_DIV     = 5'b00100;
    localparam logic [OP_W-1:0] OP_LOAD    = 5'b01011;
    localparam logic [OP_W-1:0] OP_STORE   = 5'b01100;
    localparam logic [OP_W-1:0] OP_COMPARE = 5'b11001;
    localparam logic [OP_W-1:0] OP_HALT    = 5'b11111;

    // Bit positions inside the {zero,carry,ac,parity} flag nibble
    localparam int FLG_Z  = 3;
    localparam int FLG_C  = 2;
    localparam int FLG_AC = 1;
    localparam int FLG_P  = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WB_LO,
        ST_WB,
        ST_HALT
    } wb_state_t;

    typedef struct packed {
        logic two_beat;
        logic writes_rf;
        logic writes_mem;
        logic updates_flags;
        logic is_halt;
    } op_class_t;

    function automatic logic is_alu(input logic [OP_W-1:0] op);
        return op inside {[5'd1:5'd2], [5'd5:5'd10], [5'd16:5'd21]};
    endfunction

    function automatic logic is_two_beat(input logic [OP_W-1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic logic writes_rf(input logic [OP_W-1:0] op);
        return is_alu(op) || is_two_beat(op)
            || (op == OP_MOVE) || (op == OP_LOAD);
    endfunction

    function automatic logic writes_mem(input logic [OP_W-1:0] op);
        return op == OP_STORE;
    endfunction

    function automatic logic updates_flags(input logic [OP_W-1:0] op);
        return is_alu(op) || is_two_beat(op) || (op == OP_COMPARE);
    endfunction

endpackage

// File: rtl/wb_class_decode.sv
// Combinational opcode-class decode for the writeback stage.
// Pure function of the opcode; no state.
module wb_class_decode
    import core_pkg::*;
(
    input  logic [OP_W-1:0] opcode,
    output op_class_t       cls
);

    always_comb begin
        cls               = '0;
        cls.two_beat      = is_two_beat(opcode);
        cls.writes_rf     = writes_rf(opcode);
        cls.writes_mem    = writes_mem(opcode);
        cls.updates_flags = updates_flags(opcode);
        cls.is_halt       = (opcode == OP_HALT);
    end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: commits register/memory writes and flags,
// splits 16-bit MUL/DIV results over two beats, owns halt and instret.
module writeback_stage
    import core_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int REG_AW = 3,
    parameter int MEM_AW = 4,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ex_valid,
    output logic                ex_ready,
    input  logic [OP_W-1:0]     opcode,
    input  logic [REG_AW-1:0]   rd,
    input  logic [MEM_AW-1:0]   mem_addr,
    input  logic [2*DATA_W-1:0] result,
    input  logic [3:0]          flags_in,
    output logic                rf_we,
    output logic [REG_AW-1:0]   rf_waddr,
    output logic [DATA_W-1:0]   rf_wdata,
    output logic                mem_we,
    output logic [MEM_AW-1:0]   mem_waddr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [3:0]          flags_q,
    output logic                retire,
    output logic                halted,
    output logic [CNT_W-1:0]    instret
);

    wb_state_t state, state_nxt;

    logic [OP_W-1:0]     op_q;
    logic [REG_AW-1:0]   rd_q;
    logic [MEM_AW-1:0]   addr_q;
    logic [2*DATA_W-1:0] res_q;
    logic [3:0]          flg_in_q;
    op_class_t           cls;
    logic                xfer;

    wb_class_decode u_dec (
        .opcode (op_q),
        .cls    (cls)
    );

    assign xfer = ex_valid && ex_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (xfer) begin
                    state_nxt = is_two_beat(opcode) ? ST_WB_LO : ST_WB;
                end
            end
            ST_WB_LO: state_nxt = ST_WB;
            ST_WB: begin
                if (cls.is_halt) begin
                    state_nxt = ST_HALT;
                end else if (xfer) begin
                    state_nxt = is_two_beat(opcode) ? ST_WB_LO : ST_WB;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_HALT: state_nxt = ST_HALT;
        endcase
    end

    // Address/data are forced to 0 whenever their strobe is low
    always_comb begin
        ex_ready  = 1'b0;
        rf_we     = 1'b0;
        rf_waddr  = '0;
        rf_wdata  = '0;
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        retire    = 1'b0;
        halted    = 1'b0;
        unique case (state)
            ST_IDLE: ex_ready = 1'b1;
            ST_WB_LO: begin
                rf_we    = 1'b1;
                rf_waddr = rd_q;
                rf_wdata = res_q[DATA_W-1:0];
            end
            ST_WB: begin
                retire   = 1'b1;
                ex_ready = !cls.is_halt;
                if (cls.two_beat) begin
                    rf_we    = 1'b1;
                    rf_waddr = rd_q + REG_AW'(1);
                    rf_wdata = res_q[2*DATA_W-1:DATA_W];
                end else if (cls.writes_rf) begin
                    rf_we    = 1'b1;
                    rf_waddr = rd_q;
                    rf_wdata = res_q[DATA_W-1:0];
                end
                if (cls.writes_mem) begin
                    mem_we    = 1'b1;
                    mem_waddr = addr_q;
                    mem_wdata = res_q[DATA_W-1:0];
                end
            end
            ST_HALT: halted = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q     <= '0;
            rd_q     <= '0;
            addr_q   <= '0;
            res_q    <= '0;
            flg_in_q <= '0;
            flags_q  <= '0;
            instret  <= '0;
        end else begin
            if (xfer) begin
                op_q     <= opcode;
                rd_q     <= rd;
                addr_q   <= mem_addr;
                res_q    <= result;
                flg_in_q <= {flags_in[FLG_Z], flags_in[FLG_C],
                             flags_in[FLG_AC], flags_in[FLG_P]};
            end
            if (state == ST_WB) begin
                instret <= instret + CNT_W'(1);
                if (cls.updates_flags) begin
                    flags_q <= flg_in_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed scenarios plus random traffic
// checked every cycle against a queue-of-beats reference model.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic [4:0]  opcode = '0;
    logic [2:0]  rd = '0;
    logic [3:0]  mem_addr = '0;
    logic [15:0] result = '0;
    logic [3:0]  flags_in = '0;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [7:0]  rf_wdata;
    logic        mem_we;
    logic [3:0]  mem_waddr;
    logic [7:0]  mem_wdata;
    logic [3:0]  flags_q;
    logic        retire;
    logic        halted;
    logic [15:0] instret;

    writeback_stage dut (
        .clk       (clk),
        .reset     (reset),
        .ex_valid  (ex_valid),
        .ex_ready  (ex_ready),
        .opcode    (opcode),
        .rd        (rd),
        .mem_addr  (mem_addr),
        .result    (result),
        .flags_in  (flags_in),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .flags_q   (flags_q),
        .retire    (retire),
        .halted    (halted),
        .instret   (instret)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // One expected output cycle of the stage
    typedef struct packed {
        logic       rf_we;
        logic [2:0] wa;
        logic [7:0] wd;
        logic       mem_we;
        logic [3:0] ma;
        logic [7:0] md;
        logic       retire;
        logic       fl_upd;
        logic [3:0] fl;
        logic       halt;
    } beat_t;

    beat_t       q[$];
    logic [3:0]  m_flags = '0;
    logic [15:0] m_instret = '0;
    logic        m_halted = 1'b0;
    logic        acc_last = 1'b0;

    function automatic logic m_ready();
        return !m_halted && (q.size() == 0 ||
               (q.size() == 1 && !q[0].halt));
    endfunction

    task automatic push_instr(input logic [4:0] op, input logic [2:0] r,
                              input logic [3:0] a, input logic [15:0] res,
                              input logic [3:0] f);
        beat_t b;
        logic alu, mov, st, cmp;
        alu = op inside {5'd1, 5'd2, [5'd5:5'd10], [5'd16:5'd21]};
        mov = op inside {5'd0, 5'd11};
        st  = (op == 5'd12);
        cmp = (op == 5'd25);
        b = '0;
        if (op == 5'd3 || op == 5'd4) begin
            b.rf_we = 1'b1;
            b.wa    = r;
            b.wd    = res[7:0];
            q.push_back(b);
            b.wa     = r + 3'd1;
            b.wd     = res[15:8];
            b.retire = 1'b1;
            b.fl_upd = 1'b1;
            b.fl     = f;
            q.push_back(b);
        end else begin
            b.rf_we  = alu | mov;
            b.wa     = (alu | mov) ? r : 3'd0;
            b.wd     = (alu | mov) ? res[7:0] : 8'd0;
            b.mem_we = st;
            b.ma     = st ? a : 4'd0;
            b.md     = st ? res[7:0] : 8'd0;
            b.retire = 1'b1;
            b.fl_upd = alu | cmp;
            b.fl     = f;
            b.halt   = (op == 5'd31);
            q.push_back(b);
        end
    endtask

    // Reference model: advance one beat per edge, enqueue accepted work
    initial begin : model
        beat_t b;
        logic  xf;
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                q.delete();
                m_flags   = '0;
                m_instret = '0;
                m_halted  = 1'b0;
                acc_last  = 1'b0;
            end else begin
                xf = ex_valid && m_ready();
                if (q.size() > 0) begin
                    b = q.pop_front();
                    if (b.retire) m_instret = m_instret + 16'd1;
                    if (b.fl_upd) m_flags = b.fl;
                    if (b.halt) m_halted = 1'b1;
                end
                if (xf) push_instr(opcode, rd, mem_addr, result, flags_in);
                acc_last = xf;
            end
        end
    end

    initial begin : compare
        beat_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                e = (q.size() > 0) ? q[0] : '0;
                chk("rf_we", rf_we, e.rf_we);
                chk("rf_waddr", rf_waddr, e.wa);
                chk("rf_wdata", rf_wdata, e.wd);
                chk("mem_we", mem_we, e.mem_we);
                chk("mem_waddr", mem_waddr, e.ma);
                chk("mem_wdata", mem_wdata, e.md);
                chk("retire", retire, e.retire);
                chk("ex_ready", ex_ready, m_ready());
                chk("halted", halted, m_halted);
                chk("flags_q", flags_q, m_flags);
                chk("instret", instret, m_instret);
            end
        end
    end

    task automatic present(input logic [4:0] op, input logic [2:0] r,
                           input logic [3:0] a, input logic [15:0] res,
                           input logic [3:0] f);
        opcode   = op;
        rd       = r;
        mem_addr = a;
        result   = res;
        flags_in = f;
        ex_valid = 1'b1;
    endtask

    task automatic wait_acc(input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!acc_last && n < 20);
        if (!acc_last) begin
            tests++;
            fails++;
            $display("FAIL %s: no handshake within 20 cycles", nm);
        end
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b0;
        #2 reset = 1'b1;
    endtask

    initial begin : stim
        repeat (2) @(negedge clk);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_flags", flags_q, 0);
        chk("rst_instret", instret, 0);
        chk("rst_halted", halted, 0);
        chk("rst_retire", retire, 0);
        reset = 1'b1;
        @(negedge clk);

        present(5'd3, 3'd2, 4'd0, 16'hBEEF, 4'hF);
        wait_acc("mul_abort");
        ex_valid = 1'b0;
        chk("abort_lo_we", rf_we, 1);
        #1 reset = 1'b0;
        #1;
        chk("abort_rf_we", rf_we, 0);
        chk("abort_flags", flags_q, 0);
        chk("abort_instret", instret, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_ready", ex_ready, 1);

        present(5'd1, 3'd3, 4'd0, 16'h00A5, 4'b0101);
        wait_acc("add");
        ex_valid = 1'b0;
        chk("add_we", rf_we, 1);
        chk("add_waddr", rf_waddr, 3);
        chk("add_wdata", rf_wdata, 8'hA5);
        chk("add_retire", retire, 1);
        @(negedge clk);
        chk("add_flags", flags_q, 4'b0101);
        chk("add_instret", instret, 1);

        present(5'd3, 3'd7, 4'd0, 16'h1234, 4'b0011);
        wait_acc("mul7");
        ex_valid = 1'b0;
        chk("mul_lo_addr", rf_waddr, 7);
        chk("mul_lo_data", rf_wdata, 8'h34);
        chk("mul_lo_ready", ex_ready, 0);
        chk("mul_lo_retire", retire, 0);
        @(negedge clk);
        chk("mul_hi_we", rf_we, 1);
        chk("mul_hi_addr", rf_waddr, 0);
        chk("mul_hi_data", rf_wdata, 8'h12);
        chk("mul_hi_retire", retire, 1);
        @(negedge clk);
        chk("mul_flags", flags_q, 4'b0011);
        chk("mul_instret", instret, 2);

        present(5'd12, 3'd0, 4'hC, 16'h0077, 4'hF);
        wait_acc("store");
        present(5'd0, 3'd1, 4'd0, 16'h005A, 4'hF);
        chk("st_mem_we", mem_we, 1);
        chk("st_addr", mem_waddr, 4'hC);
        chk("st_data", mem_wdata, 8'h77);
        chk("st_rf_we", rf_we, 0);
        wait_acc("move");
        ex_valid = 1'b0;
        chk("mv_we", rf_we, 1);
        chk("mv_addr", rf_waddr, 1);
        chk("mv_data", rf_wdata, 8'h5A);
        chk("mv_mem_we", mem_we, 0);
        @(negedge clk);
        chk("mv_flags", flags_q, 4'b0011);
        chk("mv_instret", instret, 4);

        present(5'd14, 3'd5, 4'd0, 16'h00FF, 4'hF);
        wait_acc("branch");
        present(5'd25, 3'd6, 4'd0, 16'h00EE, 4'b1000);
        chk("br_retire", retire, 1);
        chk("br_rf_we", rf_we, 0);
        chk("br_mem_we", mem_we, 0);
        wait_acc("compare");
        ex_valid = 1'b0;
        chk("cmp_retire", retire, 1);
        chk("cmp_rf_we", rf_we, 0);
        chk("cmp_flags_old", flags_q, 4'b0011);
        @(negedge clk);
        chk("cmp_flags", flags_q, 4'b1000);
        chk("cmp_instret", instret, 6);

        for (int c = 0; c < 3000; c++) begin
            if (!(ex_valid && !acc_last)) begin
                ex_valid = ($urandom_range(0, 3) != 0);
                opcode   = ($urandom_range(0, 49) == 0) ? 5'd31
                         : 5'($urandom_range(0, 30));
                rd       = 3'($urandom);
                mem_addr = 4'($urandom);
                result   = 16'($urandom);
                flags_in = 4'($urandom);
            end
            if ((m_halted && $urandom_range(0, 3) == 0) ||
                $urandom_range(0, 199) == 0) begin
                pulse_reset();
            end
            @(negedge clk);
        end

        ex_valid = 1'b0;
        pulse_reset();
        @(negedge clk);
        present(5'd31, 3'd0, 4'd0, 16'h0000, 4'hF);
        wait_acc("halt");
        present(5'd1, 3'd2, 4'd0, 16'h0011, 4'b0001);
        chk("halt_retire", retire, 1);
        chk("halt_ready", ex_ready, 0);
        chk("halt_not_yet", halted, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("halted", halted, 1);
            chk("halted_ready", ex_ready, 0);
            chk("halted_rf_we", rf_we, 0);
            chk("halted_instret", instret, 1);
            chk("halted_flags", flags_q, 0);
        end
        ex_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage of the 8-bit core. It accepts one executed instruction per handshake from the execute stage and commits it: register-file writes, data-memory stores and the architectural flag register.
- 16-bit results from multiply and divide are committed over two register-write beats.
- It owns the halt state and a retired-instruction counter.

Parameters:
DATA_W, 8, data byte width
REG_AW, 3, register address width (8 registers)
MEM_AW, 4, data-memory address width
CNT_W, 16, retired-instruction counter width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
ex_valid  in  1  execute stage presents an instruction
ex_ready  out  1  writeback can accept this cycle
opcode  in  5  opcode of presented instruction
rd  in  REG_AW  destination register
mem_addr  in  MEM_AW  store address
result  in  2*DATA_W  execute result ([15:8] = high/remainder)
flags_in  in  4  {zero,carry,ac,parity} from execute
rf_we  out  1  register-file write strobe
rf_waddr  out  REG_AW  register write address
rf_wdata  out  DATA_W  register write data
mem_we  out  1  data-memory write strobe
mem_waddr  out  MEM_AW  memory write address
mem_wdata  out  DATA_W  memory write data
flags_q  out  4  architectural flags {zero,carry,ac,parity}
retire  out  1  one-cycle pulse per committed instruction
halted  out  1  core halted
instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset (async, reset=0): state IDLE; all strobes 0; waddr/wdata 0; flags_q 0; instret 0; halted 0; capture registers cleared. The reset does not wait for a clock edge and aborts any in-flight beat, with no write issued.
- Transfer occurs on a rising edge when ex_valid && ex_ready. opcode, rd, mem_addr, result and flags_in are captured.
- Opcode classes:
  - ALU (00001-00010, 00101-01010, 10000-10101): single beat; rd <= result[7:0]; flags latched.
  - MUL 00011 / DIV 00100: two beats. Beat 1: rd <= result[7:0]. Beat 2: (rd+1) mod 8 <= result[15:8]. Flags latched on beat 2.
  - MOVE 00000, LOAD 01011: single beat; rd <= result[7:0]; flags unchanged.
  - STORE 01100: single beat; mem[mem_addr] <= result[7:0]; flags unchanged.
  - COMPARE 11001: no write; flags latched.
  - JUMP 01101, BRANCH 01110/10110/10111/11000, undefined opcodes: no write; flags unchanged; still retire.
  - HALT 11111: no write; retire; then HALT.
- States:
  - IDLE: ex_ready=1; no strobes. On transfer: MUL/DIV -> WB_LO, else -> WB.
  - WB_LO: rf_we=1 for the low byte; ex_ready=0; next WB (high byte).
  - WB: final beat. Strobes per class; retire=1; flags_q and instret update at the end of the cycle. ex_ready = !(captured opcode==HALT).
    - Captured HALT -> HALT.
    - New transfer in the same cycle -> WB_LO/WB, giving back-to-back throughput of 1 instruction per cycle.
    - Otherwise -> IDLE.
  - HALT: ex_ready=0; halted=1; no strobes. Exits only via reset.
- Latency: transfer at edge N puts the strobe in the cycle after N; the write is committed by the consumer at edge N+1. MUL/DIV occupy 2 cycles.
- Strobe outputs are decoded from state plus the capture registers and are glitch-free relative to clk. Write address and data are valid whenever the matching strobe is 1, and 0 otherwise.
- rd=7 for MUL/DIV writes its high byte to register 0 (wrap).
- instret wraps from all-ones to 0.
- ex_valid while ex_ready=0: the inputs are ignored. Execute must hold them stable until the transfer.

Decomposition:
- Shared package core_pkg: opcode localparams (OP_MOVE … OP_HALT), flag bit indices, and the opcode-class decode function (is_two_beat, writes_rf, writes_mem, updates_flags).
- Sub-module wb_class_decode (combinational opcode-class decode) is natural. The FSM, capture registers and counter stay in writeback_stage.

Test Plan:
- Reset mid-WB_LO: MUL rd=2 accepted, reset dropped for one cycle -> no rf_we; flags_q=0; instret=0; ex_ready=1 after release.
- ADD rd=3 result=0x00A5 flags_in=4'b0101 -> one cycle later rf_we=1, waddr=3, wdata=0xA5, retire=1; flags_q=4'b0101 next cycle; instret=1.
- MUL rd=7 result=0x1234 -> beat 1: waddr=7, wdata=0x34, ex_ready=0; beat 2: waddr=0, wdata=0x12, flags latched; total 2 cycles.
- STORE mem_addr=0xC result=0x0077, then MOVE rd=1 back-to-back with ex_valid held -> mem_we (addr C, data 0x77) then rf_we (addr 1) on consecutive cycles, no bubble; flags_q unchanged.
- BRANCH then COMPARE flags_in=4'b1000 -> no rf_we/mem_we; two retire pulses; flags_q=4'b1000 only after COMPARE.
- HALT followed by ex_valid=1 ADD -> HALT retires; halted=1; ex_ready stays 0; ADD never written; instret frozen until reset.
